// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared half-precision field layout, special encodings and rounding modes
package fpu_types_pkg;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam logic [15:0] HALF_NAN  = 16'h7E00;
    localparam logic [15:0] HALF_INF  = 16'h7C00;
    localparam logic [15:0] HALF_INFN = 16'hFC00;
    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;
    typedef enum logic [1:0] {RNE, ROUND_ZERO, ROUND_INF, ROUND_INFN} fpu_rounding_mode_t;
endpackage

// File: rtl/float_to_int_round.sv
// float_to_int_round: rounding increment, int16 saturation and sign application
module float_to_int_round
    import fpu_types_pkg::*;
(
    input  logic [15:0]        mag,
    input  logic               rnd,
    input  logic               sticky,
    input  logic               sign,
    input  fpu_rounding_mode_t mode,
    output logic [15:0]        result,
    output logic               invalid,
    output logic               inexact
);
    logic        inc;
    logic [16:0] sum;
    always_comb begin
        inc = mode == RNE        ? rnd & (sticky | mag[0]) :
              mode == ROUND_INF  ? ~sign & (rnd | sticky) :
              mode == ROUND_INFN ? sign & (rnd | sticky) : 1'b0;
        sum = {1'b0, mag} + {16'b0, inc};
        // -32768 is representable, +32768 is not
        invalid = sign ? sum > 17'd32768 : sum > 17'd32767;
        result  = invalid ? (sign ? INT16_MIN : INT16_MAX) :
                  sign ? ~sum[15:0] + 16'd1 : sum[15:0];
        inexact = ~invalid & (rnd | sticky);
    end
endmodule

// File: rtl/float_to_int.sv
// float_to_int: multi-cycle half-precision to int16 converter with
// one-bit-per-cycle alignment shifter and valid/ready handshakes
module float_to_int
    import fpu_types_pkg::*;
#(
    parameter int MAX_RSHIFT = 12
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        float_in,
    input  fpu_rounding_mode_t rounding_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        int_out,
    output logic               invalid,
    output logic               inexact
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
    localparam logic [4:0] MAX_R = 5'(MAX_RSHIFT);

    state_t             state, state_nx;
    logic [15:0]        mag;
    logic               rnd, sticky, sign, left;
    fpu_rounding_mode_t mode;
    logic [4:0]         cnt;

    logic [EXP_W-1:0]  exp, exp_m, lcnt, rcnt, n;
    logic [FRAC_W-1:0] frac;
    logic [10:0]       sig;
    logic              special, go_left, skip;
    logic [15:0]       sp_out, r_out;
    logic              r_inv, r_inx;

    // value = sig * 2^(max(exp,1) - 25): exponents 25..30 shift left, below shift right
    always_comb begin
        exp     = float_in[14:10];
        frac    = float_in[9:0];
        sig     = {exp != '0, frac};
        exp_m   = exp == '0 ? 5'd1 : exp;
        special = &exp | (exp == '0 && frac == '0);
        go_left = exp_m >= 5'd25;
        lcnt    = exp_m - 5'd25;
        rcnt    = 5'd25 - exp_m;
        skip    = ~go_left & (rcnt > MAX_R);
        n       = go_left ? lcnt : skip ? 5'd0 : rcnt;
        sp_out  = exp == '0 ? 16'h0000 : (float_in[15] && frac == '0) ? INT16_MIN : INT16_MAX;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = !in_valid ? IDLE : special ? DONE : n == '0 ? ROUND : SHIFT;
            SHIFT: state_nx = cnt == 5'd1 ? ROUND : SHIFT;
            ROUND: state_nx = DONE;
            DONE:  state_nx = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= IDLE;
        else       state <= state_nx;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    float_to_int_round u_round (
        .mag    (mag),
        .rnd    (rnd),
        .sticky (sticky),
        .sign   (sign),
        .mode   (mode),
        .result (r_out),
        .invalid(r_inv),
        .inexact(r_inx)
    );

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            mag     <= '0;
            rnd     <= 1'b0;
            sticky  <= 1'b0;
            sign    <= 1'b0;
            left    <= 1'b0;
            mode    <= RNE;
            cnt     <= '0;
            int_out <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign   <= float_in[15];
                    mode   <= rounding_mode;
                    left   <= go_left;
                    cnt    <= n;
                    mag    <= skip ? 16'd0 : {5'd0, sig};
                    rnd    <= 1'b0;
                    sticky <= skip & (|sig);
                    if (special) begin
                        int_out <= sp_out;
                        invalid <= exp != '0;
                        inexact <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 5'd1;
                    if (left) mag <= mag << 1;
                    else begin
                        mag    <= mag >> 1;
                        rnd    <= mag[0];
                        sticky <= sticky | rnd;
                    end
                end
                ROUND: begin
                    int_out <= r_out;
                    invalid <= r_inv;
                    inexact <= r_inx;
                end
                default: ;
            endcase
        end
endmodule
